// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath/board.
// master = controller side, slave = datapath/board side.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       instr;
  logic             z_flag;
  logic             n_flag;
  logic             mem_ready;
  logic             run;
  logic             step;
  logic             pc_write;
  logic             addr_sel;
  logic             mem_read;
  logic             mem_write;
  logic             ir_load;
  logic             mdr_load;
  logic             r1r2_load;
  logic             r1_sel;
  logic             alu1_sel;
  logic [2:0]       alu2_sel;
  logic [2:0]       alu_op;
  logic             aluout_write;
  logic             rf_write;
  logic             reg_in_sel;
  logic             flag_write;
  logic             halted;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  instr, z_flag, n_flag, mem_ready, run, step,
    output pc_write, addr_sel, mem_read, mem_write, ir_load, mdr_load, r1r2_load, r1_sel,
           alu1_sel, alu2_sel, alu_op, aluout_write, rf_write, reg_in_sel, flag_write,
           halted, state, instr_count
  );

  modport slave (
    output instr, z_flag, n_flag, mem_ready, run, step,
    input  pc_write, addr_sel, mem_read, mem_write, ir_load, mdr_load, r1r2_load, r1_sel,
           alu1_sel, alu2_sel, alu_op, aluout_write, rf_write, reg_in_sel, flag_write,
           halted, state, instr_count
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Fetch/decode/execute/writeback sequencer for the multicycle datapath, with memory
// wait states, run/single-step control and a saturating retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input logic               clock,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StExecAlu  = 4'd3,
    StWbAlu    = 4'd4,
    StMemLoad  = 4'd5,
    StWbLoad   = 4'd6,
    StMemStore = 4'd7,
    StBranch   = 4'd8,
    StStepWait = 4'd9,
    StHalt     = 4'd10
  } state_e;

  state_e           state_q, state_d, retire_next;
  logic             retire;
  logic [CNT_W-1:0] count_q;

  logic mem_read_q, addr_sel_q, mem_write_q, r1r2_load_q, alu1_sel_q;
  logic aluout_write_q, rf_write_q, reg_in_sel_q, flag_write_q, halted_q;

  logic op_load, op_store, op_add, op_sub, op_nand, op_ori, op_shift;
  logic op_bz, op_bnz, op_bpz, op_stop, op_alu, op_branch, taken, fetch_done;

  assign op_load   = bus.instr == 4'b0000;
  assign op_store  = bus.instr == 4'b0010;
  assign op_add    = bus.instr == 4'b0100;
  assign op_sub    = bus.instr == 4'b0110;
  assign op_nand   = bus.instr == 4'b1000;
  assign op_ori    = bus.instr[2:0] == 3'b111;
  assign op_shift  = bus.instr[2:0] == 3'b011;
  assign op_bz     = bus.instr == 4'b0101;
  assign op_bnz    = bus.instr == 4'b1001;
  assign op_bpz    = bus.instr == 4'b1101;
  assign op_stop   = bus.instr == 4'b0001;
  assign op_alu    = op_add | op_sub | op_nand | op_ori | op_shift;
  assign op_branch = op_bz | op_bnz | op_bpz;
  assign taken     = (op_bz & bus.z_flag) | (op_bnz & ~bus.z_flag) | (op_bpz & ~bus.n_flag);

  assign fetch_done = (state_q == StFetch) & bus.mem_ready;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    retire_next = bus.run ? StFetch : StStepWait;
    unique case (state_q)
      StReset:    state_d = bus.run ? StFetch : StStepWait;
      StFetch:    if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        if (op_alu) begin
          state_d = StExecAlu;
        end else if (op_load) begin
          state_d = StMemLoad;
        end else if (op_store) begin
          state_d = StMemStore;
        end else if (op_branch) begin
          state_d = StBranch;
        end else if (op_stop) begin
          // STOP counts as retired even though it parks in HALT.
          state_d = StHalt;
          retire  = 1'b1;
        end else begin
          state_d = retire_next;
          retire  = 1'b1;
        end
      end
      StExecAlu:  state_d = StWbAlu;
      StWbAlu: begin
        state_d = retire_next;
        retire  = 1'b1;
      end
      StMemLoad:  if (bus.mem_ready) state_d = StWbLoad;
      StWbLoad: begin
        state_d = retire_next;
        retire  = 1'b1;
      end
      StMemStore: begin
        if (bus.mem_ready) begin
          state_d = retire_next;
          retire  = 1'b1;
        end
      end
      StBranch: begin
        state_d = retire_next;
        retire  = 1'b1;
      end
      StStepWait: if (bus.run || bus.step) state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StReset;
    endcase
  end

  // State-only controls are registered from the next state so they are glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StReset;
      count_q        <= '0;
      mem_read_q     <= 1'b0;
      addr_sel_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      r1r2_load_q    <= 1'b0;
      alu1_sel_q     <= 1'b0;
      aluout_write_q <= 1'b0;
      rf_write_q     <= 1'b0;
      reg_in_sel_q   <= 1'b0;
      flag_write_q   <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire && (count_q != '1)) count_q <= count_q + CNT_W'(1);
      mem_read_q     <= (state_d == StFetch) || (state_d == StMemLoad);
      addr_sel_q     <= (state_d == StMemLoad) || (state_d == StMemStore);
      mem_write_q    <= state_d == StMemStore;
      r1r2_load_q    <= state_d == StDecode;
      alu1_sel_q     <= state_d == StExecAlu;
      aluout_write_q <= state_d == StExecAlu;
      rf_write_q     <= (state_d == StWbAlu) || (state_d == StWbLoad);
      reg_in_sel_q   <= state_d == StWbLoad;
      flag_write_q   <= state_d == StWbAlu;
      halted_q       <= state_d == StHalt;
    end
  end

  // ALU selects depend on the IR, which is only valid after the fetch edge.
  always_comb begin
    bus.alu2_sel = 3'b000;
    bus.alu_op   = 3'b000;
    if (fetch_done) begin
      bus.alu2_sel = 3'b001;
    end else if (state_q == StExecAlu) begin
      if (op_ori) begin
        bus.alu2_sel = 3'b011;
        bus.alu_op   = 3'b010;
      end else if (op_shift) begin
        bus.alu2_sel = 3'b100;
        bus.alu_op   = 3'b100;
      end else if (op_sub) begin
        bus.alu_op   = 3'b001;
      end else if (op_nand) begin
        bus.alu_op   = 3'b011;
      end
    end else if (state_q == StBranch) begin
      bus.alu2_sel = 3'b010;
    end
  end

  assign bus.ir_load      = fetch_done;
  assign bus.pc_write     = fetch_done | ((state_q == StBranch) & taken);
  assign bus.mdr_load     = (state_q == StMemLoad) & bus.mem_ready;
  assign bus.r1_sel       = (state_q == StDecode) & op_ori;
  assign bus.mem_read     = mem_read_q;
  assign bus.addr_sel     = addr_sel_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.r1r2_load    = r1r2_load_q;
  assign bus.alu1_sel     = alu1_sel_q;
  assign bus.aluout_write = aluout_write_q;
  assign bus.rf_write     = rf_write_q;
  assign bus.reg_in_sel   = reg_in_sel_q;
  assign bus.flag_write   = flag_write_q;
  assign bus.halted       = halted_q;
  assign bus.state        = state_q;
  assign bus.instr_count  = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction trace model supplies the expected
// output vector for every cycle; a few literal pins anchor the model itself.
module tb_multicycle_ctrl;
  localparam int unsigned CW = 4;  // small counter so saturation is reachable

  typedef struct packed {
    logic [3:0]    state;
    logic          pc_write, addr_sel, mem_read, mem_write, ir_load, mdr_load;
    logic          r1r2_load, r1_sel, alu1_sel;
    logic [2:0]    alu2_sel, alu_op;
    logic          aluout_write, rf_write, reg_in_sel, flag_write, halted;
    logic [CW-1:0] count;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multicycle_ctrl_if #(.CNT_W(CW)) bus ();
  multicycle_ctrl #(.CNT_W(CW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_count = 0;
  logic chk_on  = 1'b0;
  vec_t exp_v, got_v;
  logic pin_st_en = 1'b0, pin_cnt_en = 1'b0, pin_halt_en = 1'b0;
  logic [3:0]    pin_st;
  logic [CW-1:0] pin_cnt;
  logic          pin_halt;

  always_comb
    got_v = {bus.state, bus.pc_write, bus.addr_sel, bus.mem_read, bus.mem_write, bus.ir_load,
             bus.mdr_load, bus.r1r2_load, bus.r1_sel, bus.alu1_sel, bus.alu2_sel, bus.alu_op,
             bus.aluout_write, bus.rf_write, bus.reg_in_sel, bus.flag_write, bus.halted,
             bus.instr_count};

  always @(negedge clock) begin
    if (chk_on) begin
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL vec t=%0t got=%h exp=%h", $time, got_v, exp_v);
      end
      if (pin_st_en) begin
        n_tests++;
        if (bus.state !== pin_st) begin
          n_fail++;
          $display("FAIL pin_state t=%0t got=%0d want=%0d", $time, bus.state, pin_st);
        end
      end
      if (pin_cnt_en) begin
        n_tests++;
        if (bus.instr_count !== pin_cnt) begin
          n_fail++;
          $display("FAIL pin_count t=%0t got=%0d want=%0d", $time, bus.instr_count, pin_cnt);
        end
      end
      if (pin_halt_en) begin
        n_tests++;
        if (bus.halted !== pin_halt) begin
          n_fail++;
          $display("FAIL pin_halted t=%0t got=%0b want=%0b", $time, bus.halted, pin_halt);
        end
      end
    end
  end

  function automatic vec_t idle(input logic [3:0] st);
    vec_t v;
    v       = '0;
    v.state = st;
    v.count = CW'(m_count);
    return v;
  endfunction

  task automatic cycle(input vec_t e);
    exp_v  = e;
    chk_on = 1'b1;
    @(posedge clock);
    #1;
    pin_st_en   = 1'b0;
    pin_cnt_en  = 1'b0;
    pin_halt_en = 1'b0;
  endtask

  task automatic retire_model();
    if (m_count < (1 << CW) - 1) m_count++;
  endtask

  // Expected trace of one instruction from the first fetch cycle to retirement.
  task automatic instr_run(input logic [3:0] op, input int fwaits, input int mwaits,
                           input logic z, input logic n);
    vec_t e;
    bus.z_flag = z;
    bus.n_flag = n;
    for (int i = 0; i < fwaits; i++) begin
      bus.mem_ready = 1'b0;
      e = idle(4'd1); e.mem_read = 1'b1;
      cycle(e);
    end
    bus.mem_ready = 1'b1;
    e = idle(4'd1); e.mem_read = 1'b1; e.ir_load = 1'b1; e.pc_write = 1'b1; e.alu2_sel = 3'd1;
    cycle(e);
    bus.instr = op;
    e = idle(4'd2); e.r1r2_load = 1'b1; e.r1_sel = (op == 4'b0111) || (op == 4'b1111);
    cycle(e);
    case (op)
      4'b0100, 4'b0110, 4'b1000, 4'b0111, 4'b1111, 4'b0011, 4'b1011: begin
        e = idle(4'd3); e.alu1_sel = 1'b1; e.aluout_write = 1'b1;
        case (op)
          4'b0110: e.alu_op = 3'd1;
          4'b1000: e.alu_op = 3'd3;
          4'b0111, 4'b1111: begin e.alu2_sel = 3'd3; e.alu_op = 3'd2; end
          4'b0011, 4'b1011: begin e.alu2_sel = 3'd4; e.alu_op = 3'd4; end
          default: ;
        endcase
        cycle(e);
        e = idle(4'd4); e.rf_write = 1'b1; e.flag_write = 1'b1;
        cycle(e);
      end
      4'b0000: begin
        for (int i = 0; i <= mwaits; i++) begin
          bus.mem_ready = (i == mwaits);
          e = idle(4'd5); e.addr_sel = 1'b1; e.mem_read = 1'b1; e.mdr_load = (i == mwaits);
          cycle(e);
        end
        bus.mem_ready = 1'b1;
        e = idle(4'd6); e.rf_write = 1'b1; e.reg_in_sel = 1'b1;
        cycle(e);
      end
      4'b0010: begin
        for (int i = 0; i <= mwaits; i++) begin
          bus.mem_ready = (i == mwaits);
          e = idle(4'd7); e.addr_sel = 1'b1; e.mem_write = 1'b1;
          cycle(e);
        end
        bus.mem_ready = 1'b1;
      end
      4'b0101, 4'b1001, 4'b1101: begin
        e = idle(4'd8); e.alu2_sel = 3'd2;
        e.pc_write = (op == 4'b0101) ? z : (op == 4'b1001) ? !z : !n;
        cycle(e);
      end
      default: ;
    endcase
    retire_model();
  endtask

  task automatic step_wait(input int n_cyc);
    for (int i = 0; i < n_cyc; i++) begin
      pin_st_en = 1'b1; pin_st = 4'd9;
      cycle(idle(4'd9));
    end
  endtask

  initial begin
    vec_t e;
    bus.instr = 4'b0000; bus.z_flag = 1'b0; bus.n_flag = 1'b0;
    bus.mem_ready = 1'b1; bus.run = 1'b1; bus.step = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      pin_st_en = 1'b1; pin_st = 4'd0; pin_cnt_en = 1'b1; pin_cnt = '0;
      cycle(idle(4'd0));
    end
    reset = 1'b0;
    cycle(idle(4'd0));
    pin_st_en = 1'b1; pin_st = 4'd1;
    instr_run(4'b0100, 0, 0, 1'b0, 1'b0);                      // ADD
    pin_cnt_en = 1'b1; pin_cnt = CW'(1);
    instr_run(4'b0110, 0, 0, 1'b0, 1'b0);                      // SUB
    instr_run(4'b1000, 0, 0, 1'b0, 1'b0);                      // NAND
    instr_run(4'b0111, 0, 0, 1'b0, 1'b0);                      // ORI
    instr_run(4'b1011, 0, 0, 1'b0, 1'b0);                      // SHIFT
    instr_run(4'b1111, 0, 0, 1'b0, 1'b0);                      // ORI
    instr_run(4'b0011, 0, 0, 1'b0, 1'b0);                      // SHIFT
    instr_run(4'b0000, 0, 2, 1'b0, 1'b0);                      // LOAD, 2 wait states
    instr_run(4'b0010, 2, 1, 1'b0, 1'b0);                      // STORE with fetch waits
    instr_run(4'b0101, 0, 0, 1'b1, 1'b0);                      // BZ taken
    instr_run(4'b0101, 0, 0, 1'b0, 1'b0);                      // BZ not taken
    instr_run(4'b1001, 0, 0, 1'b0, 1'b1);                      // BNZ taken
    instr_run(4'b1001, 0, 0, 1'b1, 1'b0);                      // BNZ not taken
    instr_run(4'b1101, 0, 0, 1'b1, 1'b0);                      // BPZ taken
    instr_run(4'b1101, 0, 0, 1'b0, 1'b1);                      // BPZ not taken
    instr_run(4'b1100, 0, 0, 1'b0, 1'b0);                      // undefined -> NOP
    instr_run(4'b1010, 0, 0, 1'b0, 1'b0);                      // NOP
    bus.run = 1'b0;
    instr_run(4'b1010, 0, 0, 1'b0, 1'b0);
    step_wait(5);
    bus.step = 1'b1;
    cycle(idle(4'd9));
    bus.step = 1'b0;
    pin_st_en = 1'b1; pin_st = 4'd1;
    instr_run(4'b1110, 0, 0, 1'b0, 1'b0);                      // undefined, run still 0
    step_wait(2);
    bus.run = 1'b1;
    cycle(idle(4'd9));
    instr_run(4'b0001, 0, 0, 1'b0, 1'b0);                      // STOP
    bus.step = 1'b1;
    bus.run  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pin_halt_en = 1'b1; pin_halt = 1'b1; pin_cnt_en = 1'b1; pin_cnt = CW'(15);
      e = idle(4'd10); e.halted = 1'b1;
      cycle(e);
      bus.run = 1'b1;
    end
    bus.step = 1'b0;
    #2;
    reset   = 1'b1;  // mid-cycle: checked before any further clock edge
    m_count = 0;
    pin_halt_en = 1'b1; pin_halt = 1'b0; pin_cnt_en = 1'b1; pin_cnt = '0;
    pin_st_en = 1'b1; pin_st = 4'd0;
    cycle(idle(4'd0));
    cycle(idle(4'd0));
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
